trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 111 +++++++++++
 tb/tb_trace_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// trace_buffer: circular retirement trace with arm/PC trigger, post-trigger window and valid/ready readout
module trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int POST   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_mode,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              ev_valid,
  input  logic [DATA_W-1:0] ev_pc,
  input  logic [DATA_W-1:0] ev_data,
  input  logic [3:0]        ev_rd,
  input  logic              ev_mem,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_data,
  output logic [3:0]        rd_rd,
  output logic              rd_mem,
  output logic              rd_last,
  output logic [1:0]        state,
  output logic [$clog2(DEPTH):0] count,
  output logic              wrapped
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(POST + 1);
  localparam int EW = 2 * DATA_W + 5;
  localparam logic [PW-1:0] POSTV = PW'(POST);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;
  state_t st, st_n;
  logic [AW-1:0] wptr, rptr, wptr_n;
  logic [CW-1:0] cnt, rem, cnt_n;
  logic [PW-1:0] post, post_n;
  logic [DATA_W-1:0] tpc;
  logic wrp, wr, hit, done, rd_hs, last;
  logic [EW-1:0] buf_q [DEPTH];
  assign wr     = ev_valid && !abort && (st == ARMED || st == CAPTURE);
  assign hit    = wr && st == ARMED && ev_pc == tpc;
  assign post_n = hit ? PW'(1) : post + 1'b1;
  assign done   = wr && (st == CAPTURE || hit) && post_n == POSTV;
  assign cnt_n  = (cnt == FULL) ? cnt : cnt + 1'b1;
  assign wptr_n = wptr + 1'b1;
  assign rd_hs  = st == READOUT && rd_ready;
  assign last   = rem == CW'(1);
  always_comb begin
    st_n = st;
    case (st)
      IDLE:    st_n = arm ? (trig_mode ? ARMED : CAPTURE) : IDLE;
      ARMED:   st_n = done ? READOUT : hit ? CAPTURE : ARMED;
      CAPTURE: st_n = done ? READOUT : CAPTURE;
      default: st_n = (rd_hs && last) ? IDLE : READOUT;
    endcase
    if (abort) st_n = IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= IDLE;
      cnt  <= '0;
      wrp  <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      rem  <= '0;
      post <= '0;
      tpc  <= '0;
    end else begin
      st <= st_n;
      if (abort) begin
        cnt  <= '0;
        wrp  <= 1'b0;
        wptr <= '0;
        rptr <= '0;
        rem  <= '0;
        post <= '0;
      end else if (st == IDLE && arm) begin
        cnt  <= '0;
        wrp  <= 1'b0;
        wptr <= '0;
        post <= '0;
        tpc  <= trig_pc;
      end else if (wr) begin
        wptr <= wptr_n;
        cnt  <= cnt_n;
        if (cnt == FULL) wrp <= 1'b1;
        if (st == CAPTURE || hit) post <= post_n;
        // oldest entry sits count slots behind the post-write pointer
        if (done) begin
          rptr <= wptr_n - cnt_n[AW-1:0];
          rem  <= cnt_n;
        end
      end else if (rd_hs) begin
        rptr <= rptr + 1'b1;
        rem  <= rem - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) buf_q[wptr] <= {ev_pc, ev_data, ev_rd, ev_mem};
  end
  assign {rd_pc, rd_data, rd_rd, rd_mem} = buf_q[rptr];
  assign rd_valid = st == READOUT;
  assign rd_last  = rd_valid && last;
  assign state    = st;
  assign count    = cnt;
  assign wrapped  = wrp;
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: randomized scenarios checked against a queue-based trace model
module tb_trace_buffer;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int P  = 4;
  logic clk = 0, reset = 1, arm = 0, abort = 0, trig_mode = 0;
  logic [DW-1:0] trig_pc = '0, ev_pc = '0, ev_data = '0;
  logic ev_valid = 0, ev_mem = 0, rd_ready = 0;
  logic [3:0] ev_rd = '0;
  logic rd_valid, rd_mem, rd_last, wrapped;
  logic [DW-1:0] rd_pc, rd_data;
  logic [3:0] rd_rd, count;
  logic [1:0] state;
  int total = 0, bad = 0;
  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] data;
    logic [3:0] rd;
    logic m;
  } ent_t;
  ent_t mq[$];
  logic [1:0] mph = 0;
  int mpost = 0;
  logic mwrap = 0;
  logic [DW-1:0] mtpc = '0;
  trace_buffer #(.DATA_W(DW), .DEPTH(D), .POST(P)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trig_mode(trig_mode),
    .trig_pc(trig_pc), .ev_valid(ev_valid), .ev_pc(ev_pc), .ev_data(ev_data),
    .ev_rd(ev_rd), .ev_mem(ev_mem), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_pc(rd_pc), .rd_data(rd_data), .rd_rd(rd_rd), .rd_mem(rd_mem),
    .rd_last(rd_last), .state(state), .count(count), .wrapped(wrapped)
  );
  always #5 clk = ~clk;
  task automatic model_clear();
    mq.delete();
    mwrap = 0;
    mph = 0;
    mpost = 0;
  endtask
  task automatic step(input logic v, input logic [DW-1:0] pc, input logic ab);
    ent_t e;
    @(negedge clk);
    total++;
    if ({state, count, wrapped, rd_valid} !== {mph, 4'(mq.size()), mwrap, mph == 2'd3}) begin
      bad++;
      $display("FAIL status: state=%0d count=%0d wrapped=%0b rd_valid=%0b required state=%0d count=%0d wrapped=%0b rd_valid=%0b",
               state, count, wrapped, rd_valid, mph, mq.size(), mwrap, mph == 2'd3);
    end
    arm = 0; abort = ab; rd_ready = 0;
    ev_valid = v; ev_pc = pc; ev_data = $urandom; ev_rd = 4'($urandom); ev_mem = 1'($urandom);
    if (ab) model_clear();
    else if (v && (mph == 1 || mph == 2)) begin
      e.pc = pc; e.data = ev_data; e.rd = ev_rd; e.m = ev_mem;
      mq.push_back(e);
      if (mq.size() > D) begin
        void'(mq.pop_front());
        mwrap = 1;
      end
      if (mph == 1) begin
        if (pc == mtpc) begin
          mph = 2;
          mpost = 1;
        end
      end else mpost++;
      if (mph == 2 && mpost == P) mph = 3;
    end
  endtask
  task automatic do_arm(input logic mode, input logic [DW-1:0] tpc, input logic ab);
    @(negedge clk);
    arm = 1; abort = ab; trig_mode = mode; trig_pc = tpc; rd_ready = 0;
    ev_valid = 1'($urandom); ev_pc = tpc;
    if (ab) model_clear();
    else if (mph == 0) begin
      mq.delete();
      mwrap = 0;
      mtpc = tpc;
      mpost = 0;
      mph = mode ? 2'd1 : 2'd2;
    end
  endtask
  task automatic drain(input bit hold3);
    int idx = 0, cyc = 0, stalls = 0;
    while (mph == 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      total++;
      if ({rd_valid, state, rd_pc, rd_data, rd_rd, rd_mem, rd_last, count, wrapped} !==
          {1'b1, 2'd3, mq[idx].pc, mq[idx].data, mq[idx].rd, mq[idx].m, idx == mq.size() - 1, 4'(mq.size()), mwrap}) begin
        bad++;
        $display("FAIL readout[%0d]: valid=%0b pc=%h data=%h rd=%h mem=%0b last=%0b count=%0d required pc=%h data=%h rd=%h mem=%0b last=%0b count=%0d",
                 idx, rd_valid, rd_pc, rd_data, rd_rd, rd_mem, rd_last, count,
                 mq[idx].pc, mq[idx].data, mq[idx].rd, mq[idx].m, idx == mq.size() - 1, mq.size());
      end
      abort = 0; arm = 1'($urandom); ev_valid = 1'($urandom); ev_pc = mtpc;
      if (hold3 && idx == 1 && stalls < 3) begin
        rd_ready = 0;
        stalls++;
      end else rd_ready = 1'($urandom_range(0, 1));
      if (rd_ready) begin
        if (idx == mq.size() - 1) mph = 0;
        idx++;
      end
    end
    if (mph == 3) begin
      total++;
      bad++;
      $display("FAIL readout timeout: entries read=%0d required=%0d", idx, mq.size());
      model_clear();
    end
    @(negedge clk);
    arm = 0; ev_valid = 0; rd_ready = 0;
    total++;
    if ({state, rd_valid, rd_last, count, wrapped} !== {2'd0, 1'b0, 1'b0, 4'(mq.size()), mwrap}) begin
      bad++;
      $display("FAIL after readout: state=%0d rd_valid=%0b rd_last=%0b count=%0d wrapped=%0b required state=0 count=%0d wrapped=%0b",
               state, rd_valid, rd_last, count, wrapped, mq.size(), mwrap);
    end
  endtask
  task automatic test_reset();
    #2 reset = 0;
    #1 total++;
    if ({state, count, rd_valid, rd_last, wrapped} !== 9'd0) begin
      bad++;
      $display("FAIL reset: state=%0d count=%0d rd_valid=%0b rd_last=%0b wrapped=%0b required all 0",
               state, count, rd_valid, rd_last, wrapped);
    end
    @(negedge clk) reset = 1;
    model_clear();
  endtask
  task automatic test_immediate();
    do_arm(0, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0);
    drain(0);
  endtask
  task automatic test_pc_trigger();
    do_arm(1, 32'h20, 0);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) step(0, 32'h20, 0);
      step(1, 32'(i * 4), 0);
    end
    drain(1);
  endtask
  task automatic test_abort();
    do_arm(0, 32'h0, 1);
    step(0, 32'h0, 0);
    do_arm(0, 32'h0, 0);
    step(1, 32'h0, 0);
    step(1, 32'h4, 0);
    step(1, 32'h8, 1);
    step(0, 32'h0, 0);
    do_arm(0, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 0);
    step(0, 32'h0, 1);
    step(0, 32'h0, 0);
  endtask
  task automatic test_idle_events();
    do_arm(0, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h40 + 32'(i * 4), 0);
    drain(0);
    for (int i = 0; i < 4; i++) step(1, 32'h20, 0);
  endtask
  task automatic test_async_reset();
    do_arm(0, 32'h0, 0);
    step(1, 32'h0, 0);
    step(1, 32'h4, 0);
    @(negedge clk);
    ev_valid = 0;
    #2 reset = 0;
    #1 total++;
    if ({state, count, rd_valid, rd_last, wrapped} !== 9'd0) begin
      bad++;
      $display("FAIL async reset: state=%0d count=%0d rd_valid=%0b rd_last=%0b wrapped=%0b required all 0",
               state, count, rd_valid, rd_last, wrapped);
    end
    @(negedge clk) reset = 1;
    model_clear();
    step(1, 32'h20, 0);
    step(1, 32'h24, 0);
  endtask
  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      do_arm(1'($urandom), 32'($urandom_range(0, 15) * 4), $urandom_range(0, 15) == 0);
      for (int c = 0; c < 40 && (mph == 1 || mph == 2); c++)
        step($urandom_range(0, 3) != 0, 32'($urandom_range(0, 15) * 4), $urandom_range(0, 40) == 0);
      if (mph == 1 || mph == 2) step(0, 32'h0, 1);
      if (mph == 3) drain(0);
      step(0, 32'h0, 0);
    end
  endtask
  initial begin
    test_reset();
    test_immediate();
    test_pc_trigger();
    test_abort();
    test_idle_events();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
